// File: rtl/wave_pkg.sv
// -----------------------------------------------------------------------------
// wave_pkg
// Shared definitions for the wave generator configuration/start-up sequencer:
// sequencer state encoding, shadow register field codes, channel geometry and
// a small state classification helper.
// -----------------------------------------------------------------------------
package wave_pkg;

  // Channel geometry of the generator datapath.
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 16;
  localparam int CH_IDX_W = 2;

  // Field codes carried in wr_addr[1:0]; code 3 is reserved and ignored.
  localparam logic [1:0] FLD_AMP = 2'd0;
  localparam logic [1:0] FLD_OFS = 2'd1;
  localparam logic [1:0] FLD_PHW = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RESYNC = 3'd2,
    ST_START  = 3'd3,
    ST_RUN    = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // States in which the sequencer is bringing the generator up.
  function automatic logic is_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_RESYNC) || (s == ST_START);
  endfunction

endpackage

// File: rtl/wave_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// wave_seq_ctrl_if
// Bundle of the sequencer's configuration bus, control requests and the
// generator-facing handshake.
//   master : drives wr_en/wr_addr/wr_data, commit, stop, wg_activeout
//   slave  : the sequencer; drives the active register images, wg_reset,
//            wg_activein and the busy/running/error/commit_dropped status
// -----------------------------------------------------------------------------
interface wave_seq_ctrl_if;
  import wave_pkg::*;

  logic                     wr_en;
  logic [3:0]               wr_addr;
  logic [CH_W-1:0]          wr_data;
  logic                     commit;
  logic                     stop;
  logic [NUM_CH*CH_W-1:0]   amps;
  logic [NUM_CH*CH_W-1:0]   offsets;
  logic [NUM_CH*CH_W-1:0]   phasewords;
  logic                     wg_reset;
  logic                     wg_activein;
  logic                     wg_activeout;
  logic                     busy;
  logic                     running;
  logic                     error;
  logic                     commit_dropped;

  modport master (
    output wr_en, wr_addr, wr_data, commit, stop, wg_activeout,
    input  amps, offsets, phasewords, wg_reset, wg_activein,
           busy, running, error, commit_dropped
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, commit, stop, wg_activeout,
    output amps, offsets, phasewords, wg_reset, wg_activein,
           busy, running, error, commit_dropped
  );

endinterface

// File: rtl/wave_shadow_regs.sv
// -----------------------------------------------------------------------------
// wave_shadow_regs
// 4 channels x 3 fields x 16-bit shadow register file with an atomic copy into
// the active registers that drive the generator.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_wr_en        : write strobe for the shadow file
//   i_wr_addr      : [3:2] channel, [1:0] field (3 = reserved, no effect)
//   i_wr_data      : write data
//   i_load         : copy all shadow fields into the active registers
//   o_amps, o_offsets, o_phasewords : active images, channel k at [16k+15:16k]
// -----------------------------------------------------------------------------
module wave_shadow_regs
  import wave_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_wr_en,
  input  logic [3:0]             i_wr_addr,
  input  logic [CH_W-1:0]        i_wr_data,
  input  logic                   i_load,
  output logic [NUM_CH*CH_W-1:0] o_amps,
  output logic [NUM_CH*CH_W-1:0] o_offsets,
  output logic [NUM_CH*CH_W-1:0] o_phasewords
);

  // Packed per channel so the flat output slice k is channel k.
  logic [NUM_CH-1:0][CH_W-1:0] r_shd_amp, r_shd_ofs, r_shd_phw;
  logic [NUM_CH-1:0][CH_W-1:0] r_act_amp, r_act_ofs, r_act_phw;
  logic [CH_IDX_W-1:0]         w_ch;
  logic [1:0]                  w_fld;

  assign w_ch  = i_wr_addr[3:2];
  assign w_fld = i_wr_addr[1:0];

  // Shadow file: write-decoded by field, reserved field leaves all untouched.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shd_amp <= '0;
      r_shd_ofs <= '0;
      r_shd_phw <= '0;
    end else if (i_wr_en) begin
      case (w_fld)
        FLD_AMP: r_shd_amp[w_ch] <= i_wr_data;
        FLD_OFS: r_shd_ofs[w_ch] <= i_wr_data;
        FLD_PHW: r_shd_phw[w_ch] <= i_wr_data;
        default: ;
      endcase
    end
  end

  // Active file: loaded from the pre-edge shadow, so a write in the load
  // cycle only reaches the shadow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_act_amp <= '0;
      r_act_ofs <= '0;
      r_act_phw <= '0;
    end else if (i_load) begin
      r_act_amp <= r_shd_amp;
      r_act_ofs <= r_shd_ofs;
      r_act_phw <= r_shd_phw;
    end
  end

  assign o_amps       = r_act_amp;
  assign o_offsets    = r_act_ofs;
  assign o_phasewords = r_act_phw;

endmodule

// File: rtl/wave_seq_ctrl.sv
// -----------------------------------------------------------------------------
// wave_seq_ctrl
// Configuration and start-up sequencer for the four-channel wave generator.
// A commit copies the shadow registers into the active ones (LOAD), holds the
// generator in reset for RESET_CYCLES cycles (RESYNC), then raises activein
// and waits for activeout (START). RUN on success, sticky error (ERR) when
// activeout does not arrive within FILL_TIMEOUT cycles.
//   i_clk   : system clock, rising edge
//   i_reset : synchronous active-high reset
//   bus     : wave_seq_ctrl_if.slave (config writes, commit/stop, generator
//             handshake, active register images and status)
// -----------------------------------------------------------------------------
module wave_seq_ctrl
  import wave_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int FILL_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  wave_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             w_load, w_commit_drop;
  logic             w_nxt_active;
  logic             r_wg_reset, r_activein, r_busy, r_running;
  logic             r_error, r_commit_dropped;

  // Saturating increment: the counter never wraps.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // The copy happens at the end of the single LOAD cycle.
  assign w_load = (r_state == ST_LOAD);

  // A commit is lost while busy, or when it collides with stop.
  assign w_commit_drop = bus.commit && (bus.stop || is_busy(r_state));

  // Generator is released from reset and fed in START and RUN.
  assign w_nxt_active = (w_state_nxt == ST_START) || (w_state_nxt == ST_RUN);

  // Next-state and counter decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (bus.commit) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LOAD: begin
        w_state_nxt = ST_RESYNC;
      end
      ST_RESYNC: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = ST_START;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_START: begin
        w_cnt_nxt = w_cnt_inc;
        if (bus.wg_activeout) begin
          w_state_nxt = ST_RUN;
        end else if (r_cnt == FILL_LAST) begin
          w_state_nxt = ST_ERR;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Stop overrides everything, including a same-cycle commit.
    if (bus.stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
    // Every state is entered with a cleared counter.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = w_cnt_nxt;
    end
  end

  // State, counter and outputs registered from the next state so each output
  // reflects the state it is visible in.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= ST_IDLE;
      r_cnt            <= '0;
      r_wg_reset       <= 1'b1;
      r_activein       <= 1'b0;
      r_busy           <= 1'b0;
      r_running        <= 1'b0;
      r_error          <= 1'b0;
      r_commit_dropped <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_wg_reset       <= !w_nxt_active;
      r_activein       <= w_nxt_active;
      r_busy           <= is_busy(w_state_nxt);
      r_running        <= (w_state_nxt == ST_RUN);
      r_commit_dropped <= w_commit_drop;
      // Sticky: set on timeout, cleared only by a fresh LOAD, kept over stop.
      if (w_state_nxt == ST_ERR) begin
        r_error <= 1'b1;
      end else if (w_state_nxt == ST_LOAD) begin
        r_error <= 1'b0;
      end else begin
        r_error <= r_error;
      end
    end
  end

  wave_shadow_regs u_shadow (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_wr_en      (bus.wr_en),
    .i_wr_addr    (bus.wr_addr),
    .i_wr_data    (bus.wr_data),
    .i_load       (w_load),
    .o_amps       (bus.amps),
    .o_offsets    (bus.offsets),
    .o_phasewords (bus.phasewords)
  );

  assign bus.wg_reset       = r_wg_reset;
  assign bus.wg_activein    = r_activein;
  assign bus.busy           = r_busy;
  assign bus.running        = r_running;
  assign bus.error          = r_error;
  assign bus.commit_dropped = r_commit_dropped;

endmodule

// File: doc/wave_seq_ctrl.md
Name: wave_seq_ctrl

Overview:
Configuration and start-up sequencer for the four-channel wave generator datapath (four 16-bit channels, summed output).
- Collects per-channel amplitude, offset and phase-word writes into shadow registers.
- On commit, applies them atomically, resyncs the phase accumulators via the generator reset, and raises activein.
- Declares the generator running once activeout returns; flags a fill timeout otherwise.

Parameters:
RESET_CYCLES, 4, cycles wg_reset is held after load (range 1..2^CNT_W-1)
FILL_TIMEOUT, 16, max cycles in START waiting for wg_activeout before error (range 1..2^CNT_W-1)
CNT_W, 8, width of the shared sequencing counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
wr_en  in  1  shadow register write strobe
wr_addr  in  4  [3:2] channel 0..3, [1:0] field: 0 amp, 1 offset, 2 phaseword, 3 reserved (write ignored)
wr_data  in  16  write data
commit  in  1  single-cycle request to apply shadow and (re)start
stop  in  1  single-cycle request to halt generator
amps  out  64  channel k at [16k+15:16k], signed per slice
offsets  out  64  same packing
phasewords  out  64  same packing
wg_reset  out  1  reset to generator datapath
wg_activein  out  1  generator activein
wg_activeout  in  1  generator activeout
busy  out  1  high in LOAD, RESYNC, START
running  out  1  high in RUN
error  out  1  sticky fill-timeout flag
commit_dropped  out  1  one-cycle pulse when commit is ignored

Behaviour:
- All outputs registered.
- Reset: shadow regs, amps, offsets, phasewords = 0; wg_reset=1; wg_activein=0; busy, running, error, commit_dropped = 0; state IDLE; counter 0.
- Shadow writes are accepted in every state except during reset. Field 3 is a no-op.
- States:
  - IDLE: wg_reset=1, activein=0. commit -> LOAD.
  - LOAD (1 cycle): amps/offsets/phasewords <= shadow; wg_reset=1. -> RESYNC, counter=0.
  - RESYNC: wg_reset=1 for exactly RESET_CYCLES cycles. -> START, counter=0.
  - START: wg_reset=0, activein=1, counter++. If wg_activeout=1 -> RUN. Else if counter==FILL_TIMEOUT-1 -> ERR.
  - RUN: activein=1, running=1. commit -> LOAD (restart, new values). wg_activeout dropping is ignored.
  - ERR: activein=0, wg_reset=1, error=1. commit -> LOAD. error clears on entry to LOAD.
- Commit latency: commit at cycle t (IDLE/RUN/ERR) gives LOAD at t+1, new outputs visible at t+2, wg_reset deasserted and activein=1 at t+2+RESET_CYCLES.
- Write and commit in the same cycle: that write is included in the committed values, because the copy happens in LOAD.
- Write during LOAD: lands in shadow only, not in the committed values.
- Commit while busy: ignored, commit_dropped pulses at t+1, state unaffected.
- Stop in any non-IDLE state: next state IDLE, activein=0 and wg_reset=1 at t+1. error is preserved.
- Stop and commit in the same cycle: stop wins and commit_dropped pulses.
- Active output registers keep their last values in IDLE and ERR; they change only in LOAD.
- Counter saturates and never wraps.
- Reset mid-sequence returns everything to reset values next cycle.

Decomposition:
- Shared package wave_pkg:
  - State encoding enum (IDLE, LOAD, RESYNC, START, RUN, ERR).
  - Field codes FLD_AMP=0, FLD_OFS=1, FLD_PHW=2.
  - NUM_CH=4 and CH_W=16.
- One natural sub-module, wave_shadow_regs: 4 x 3 x 16-bit write-decoded register file with a load-to-active copy. The FSM and counter stay in the top module.

Test Plan:
- Write ch3 amp=0x7FFF, ch0 phw=0x0100, commit at t; activeout tied to activein delayed 6 cycles -> amps[63:48]=0x7FFF and phasewords[15:0]=0x0100 at t+2; activein rises at t+6; running=1 at t+13.
- wg_activeout held 0 after commit -> error=1 and activein=0 exactly FILL_TIMEOUT cycles after START entry. Recommit -> error clears in LOAD.
- Commit during RESYNC -> commit_dropped pulse, the sequence timing is unchanged.
- Write ch1 offset=0x1234 in the same cycle as commit -> offsets[31:16]=0x1234 at t+2. A write in the LOAD cycle -> active value unchanged, shadow updated.
- Stop and commit together in RUN -> IDLE next cycle, activein=0, wg_reset=1, commit_dropped=1. Field-3 write changes nothing.
- Assert reset during START -> next cycle all outputs at reset values, and wg_reset=1.
